mmio_requester: RTL

//  Host-side MMIO initiator: turns a simple command stream (read/write, addr, data) into single-cycle

---
 rtl/mmio_requester_if.sv | 56 +++++
 rtl/mmio_requester.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mmio_requester_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_requester_if
//  Description : Bundle of the command, MMIO request, read response and
//                completion signals of the MMIO requester. The master view
//                belongs to the requester; the slave view belongs to whatever
//                feeds it commands and serves its MMIO requests.
//  Revision    : 1.0  initial release
// ============================================================================
interface mmio_requester_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int TID_W  = 9
);
    // command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // MMIO request toward the register file
    logic              mmio_wr_valid;
    logic              mmio_rd_valid;
    logic [ADDR_W-1:0] mmio_addr;
    logic [TID_W-1:0]  mmio_tid;
    logic [DATA_W-1:0] mmio_wdata;

    // read response from the register file
    logic              rsp_valid;
    logic [TID_W-1:0]  rsp_tid;
    logic [DATA_W-1:0] rsp_data;

    // completion and status
    logic              done_valid;
    logic [DATA_W-1:0] done_rdata;
    logic              done_err;
    logic [7:0]        stray_cnt;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_valid, rsp_tid, rsp_data,
        output cmd_ready,
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        output done_valid, done_rdata, done_err, stray_cnt
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_valid, rsp_tid, rsp_data,
        input  cmd_ready,
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        input  done_valid, done_rdata, done_err, stray_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mmio_requester.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_requester
//  Description : Host-side MMIO initiator. Accepts one read/write command at a
//                time, issues a single-cycle MMIO request pulse tagged with a
//                rolling transaction ID, waits for the TID-matched read
//                response (or times out) and signals completion with a
//                one-cycle done pulse. Responses that do not complete the
//                outstanding read are counted in a saturating stray counter.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_requester #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64,
    parameter int TID_W   = 9,
    parameter int TIMEOUT = 256
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mmio_requester_if.master  bus
);

    // Timeout counter just wide enough to reach TIMEOUT-1.
    localparam int TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
    localparam logic [7:0]        STRAY_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state;
    logic              is_write;   // latched direction of the current command
    logic [TID_W-1:0]  tid_cnt;    // TID to stamp on the next command
    logic [TCNT_W-1:0] tmo_cnt;    // cycles spent waiting for the read response

    logic              rsp_match;
    logic              stray_hit;

    // A response completes the read only while waiting and only with our TID;
    // anything else (wrong TID, or any response outside WAIT_RSP) is stray.
    assign rsp_match = bus.rsp_valid && (state == WAIT_RSP) && (bus.rsp_tid == bus.mmio_tid);
    assign stray_hit = bus.rsp_valid && !rsp_match;

    // Transaction FSM: all request and completion outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            is_write           <= 1'b0;
            tid_cnt            <= {TID_W{1'b0}};
            tmo_cnt            <= {TCNT_W{1'b0}};
            bus.cmd_ready      <= 1'b1;
            bus.mmio_wr_valid  <= 1'b0;
            bus.mmio_rd_valid  <= 1'b0;
            bus.mmio_addr      <= {ADDR_W{1'b0}};
            bus.mmio_tid       <= {TID_W{1'b0}};
            bus.mmio_wdata     <= {DATA_W{1'b0}};
            bus.done_valid     <= 1'b0;
            bus.done_rdata     <= {DATA_W{1'b0}};
            bus.done_err       <= 1'b0;
        end else begin
            // Request and completion strobes are single-cycle by default.
            bus.mmio_wr_valid <= 1'b0;
            bus.mmio_rd_valid <= 1'b0;
            bus.done_valid    <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // Capture the command straight into the request
                        // registers so the pulse appears in the next cycle.
                        is_write          <= bus.cmd_write;
                        bus.mmio_addr     <= bus.cmd_addr;
                        bus.mmio_tid      <= tid_cnt;
                        bus.mmio_wdata    <= bus.cmd_wdata;
                        bus.mmio_wr_valid <= bus.cmd_write;
                        bus.mmio_rd_valid <= !bus.cmd_write;
                        bus.cmd_ready     <= 1'b0;
                        state             <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (is_write) begin
                        // Writes are posted: complete without a response.
                        bus.done_valid <= 1'b1;
                        bus.done_rdata <= {DATA_W{1'b0}};
                        bus.done_err   <= 1'b0;
                        state          <= DONE;
                    end else begin
                        tmo_cnt <= {TCNT_W{1'b0}};
                        state   <= WAIT_RSP;
                    end
                end

                WAIT_RSP: begin
                    if (rsp_match) begin
                        // A match wins even on the last timeout cycle.
                        bus.done_valid <= 1'b1;
                        bus.done_rdata <= bus.rsp_data;
                        bus.done_err   <= 1'b0;
                        state          <= DONE;
                    end else if (tmo_cnt == TCNT_LAST) begin
                        bus.done_valid <= 1'b1;
                        bus.done_rdata <= {DATA_W{1'b0}};
                        bus.done_err   <= 1'b1;
                        state          <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // TID advances once per completed command and wraps naturally.
                    tid_cnt       <= tid_cnt + 1'b1;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end

                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of responses that did not complete the outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.stray_cnt <= 8'h00;
        end else if (stray_hit && (bus.stray_cnt != STRAY_MAX)) begin
            bus.stray_cnt <= bus.stray_cnt + 8'h01;
        end
    end

endmodule
`default_nettype wire
